// File: rtl/arcade_input_ctrl_if.sv
// Control-input bundle between the host-side sources (keyboard events, joysticks, orientation)
// and the conditioned per-player outputs feeding the arcade core.
interface arcade_input_ctrl_if;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic [6:0]  p1_csjudlr;
  logic [6:0]  p2_csjudlr;
  logic        service;

  modport master (
    output ps2_key, joystick_0, joystick_1, rotate,
    input  p1_csjudlr, p2_csjudlr, service
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1, rotate,
    output p1_csjudlr, p2_csjudlr, service
  );
endinterface

// File: rtl/arcade_input_ctrl.sv
// Keyboard/joystick conditioner with orientation remap and per-player coin pulse shaping.
// Optional macro COIN_FROM_START_EN: a start rising edge also issues a P1 coin request.
module arcade_input_ctrl #(
  parameter int unsigned CLK_HZ      = 12000000,
  parameter int unsigned COIN_MS     = 100,
  parameter int unsigned COIN_GAP_MS = 50
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  arcade_input_ctrl_if.slave  io
);

  localparam int unsigned     MS_DIV   = CLK_HZ / 1000;
  localparam int              PW       = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PW-1:0]   RELOAD   = PW'(MS_DIV - 1);
  localparam logic [7:0]      PULSE_MS = 8'(COIN_MS);
  localparam logic [7:0]      GAP_MS   = 8'(COIN_GAP_MS);

  localparam logic [4:0] K_UP1 = 5'd0,  K_DN1 = 5'd1,  K_LT1 = 5'd2,  K_RT1 = 5'd3;
  localparam logic [4:0] K_FA1 = 5'd4,  K_FB1 = 5'd5,  K_SA1 = 5'd6,  K_SB1 = 5'd7;
  localparam logic [4:0] K_CN1 = 5'd8,  K_UP2 = 5'd9,  K_DN2 = 5'd10, K_LT2 = 5'd11;
  localparam logic [4:0] K_RT2 = 5'd12, K_FI2 = 5'd13, K_SA2 = 5'd14, K_SB2 = 5'd15;
  localparam logic [4:0] K_CN2 = 5'd16, K_SVC = 5'd17;

  // IDLE: wait for request | PULSE: coin high | GAP: enforced low time
  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} coin_st_e;

  logic [PW-1:0] presc_q, presc_d;
  logic          ms_tick;
  logic          old_tog_q;
  logic [17:0]   key_q, key_d;
  logic [4:0]    key_idx;
  logic          key_hit;
  logic [7:0]    joy;
  logic          unused_joy_hi;
  logic [1:0]    coin_raw, coin_raw_q, coin_req;
  logic          start1_raw, start2_raw;
  coin_st_e      st_q [2];
  coin_st_e      st_d [2];
  logic [7:0]    cnt_q [2];
  logic [7:0]    cnt_d [2];
  logic [1:0]    pend_q, pend_d;
  logic [6:0]    p1_q, p1_d, p2_q, p2_d;
  logic          svc_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // {up,down,left,right}; Horz mode feeds each direction from its rotated neighbour
  function automatic logic [3:0] orient(input logic [3:0] udlr, input logic rot);
    return rot ? {udlr[1], udlr[0], udlr[2], udlr[3]} : udlr;
  endfunction

  assign ms_tick       = (presc_q == '0);
  assign presc_d       = ms_tick ? RELOAD : presc_q - PW'(1);
  assign joy           = io.joystick_0[7:0] | io.joystick_1[7:0];
  assign unused_joy_hi = ^{io.joystick_0[15:8], io.joystick_1[15:8]};

  always_comb begin
    key_hit = 1'b1;
    key_idx = K_UP1;
    case (io.ps2_key[8:0])
      9'h075, 9'h175: key_idx = K_UP1;
      9'h072, 9'h172: key_idx = K_DN1;
      9'h06B, 9'h16B: key_idx = K_LT1;
      9'h074, 9'h174: key_idx = K_RT1;
      9'h029:         key_idx = K_FA1;
      9'h014:         key_idx = K_FB1;
      9'h005:         key_idx = K_SA1;
      9'h016:         key_idx = K_SB1;
      9'h02E:         key_idx = K_CN1;
      9'h02D:         key_idx = K_UP2;
      9'h02B:         key_idx = K_DN2;
      9'h023:         key_idx = K_LT2;
      9'h034:         key_idx = K_RT2;
      9'h01C:         key_idx = K_FI2;
      9'h006:         key_idx = K_SA2;
      9'h01E:         key_idx = K_SB2;
      9'h036:         key_idx = K_CN2;
      9'h02C:         key_idx = K_SVC;
      default:        key_hit = 1'b0;
    endcase
    key_d = key_q;
    if ((old_tog_q != io.ps2_key[10]) && key_hit) key_d[key_idx] = io.ps2_key[9];
  end

  assign start1_raw = key_q[K_SA1] | key_q[K_SB1] | joy[5];
  assign start2_raw = key_q[K_SA2] | key_q[K_SB2] | joy[6];
  assign coin_raw   = {key_q[K_CN2], key_q[K_CN1] | joy[7]};

`ifdef COIN_FROM_START_EN
  logic [1:0] start_raw_q;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) start_raw_q <= '0;
    else          start_raw_q <= {start2_raw, start1_raw};
  end
  assign coin_req = {coin_raw[1] & ~coin_raw_q[1],
                     (coin_raw[0] & ~coin_raw_q[0]) |
                     (|({start2_raw, start1_raw} & ~start_raw_q))};
`else
  assign coin_req = coin_raw & ~coin_raw_q;
`endif

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      st_d[p]   = st_q[p];
      cnt_d[p]  = cnt_q[p];
      pend_d[p] = pend_q[p];
      case (st_q[p])
        ST_IDLE: begin
          if (coin_req[p]) begin
            st_d[p]  = ST_PULSE;
            cnt_d[p] = '0;
          end
        end
        ST_PULSE: begin
          if (coin_req[p]) pend_d[p] = 1'b1;
          if (ms_tick) begin
            if (sat_inc(cnt_q[p]) >= PULSE_MS) begin
              st_d[p]  = ST_GAP;
              cnt_d[p] = '0;
            end else begin
              cnt_d[p] = sat_inc(cnt_q[p]);
            end
          end
        end
        ST_GAP: begin
          if (coin_req[p]) pend_d[p] = 1'b1;
          if (ms_tick) begin
            if (sat_inc(cnt_q[p]) >= GAP_MS) begin
              cnt_d[p] = '0;
              if (pend_q[p] || coin_req[p]) begin
                st_d[p]   = ST_PULSE;
                pend_d[p] = 1'b0;
              end else begin
                st_d[p] = ST_IDLE;
              end
            end else begin
              cnt_d[p] = sat_inc(cnt_q[p]);
            end
          end
        end
        default: st_d[p] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    p1_d = {st_d[0] == ST_PULSE, start1_raw, key_q[K_FA1] | key_q[K_FB1] | joy[4],
            orient({key_q[K_UP1] | joy[3], key_q[K_DN1] | joy[2],
                    key_q[K_LT1] | joy[1], key_q[K_RT1] | joy[0]}, io.rotate)};
    p2_d = {st_d[1] == ST_PULSE, start2_raw, key_q[K_FI2],
            orient({key_q[K_UP2] | joy[3], key_q[K_DN2] | joy[2],
                    key_q[K_LT2] | joy[1], key_q[K_RT2] | joy[0]}, io.rotate)};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      old_tog_q  <= 1'b0;
      key_q      <= '0;
      coin_raw_q <= '0;
      pend_q     <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      svc_q      <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        st_q[p]  <= ST_IDLE;
        cnt_q[p] <= '0;
      end
    end else begin
      presc_q    <= presc_d;
      old_tog_q  <= io.ps2_key[10];
      key_q      <= key_d;
      coin_raw_q <= coin_raw;
      pend_q     <= pend_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      svc_q      <= key_q[K_SVC];
      for (int p = 0; p < 2; p++) begin
        st_q[p]  <= st_d[p];
        cnt_q[p] <= cnt_d[p];
      end
    end
  end

  assign io.p1_csjudlr = p1_q;
  assign io.p2_csjudlr = p2_q;
  assign io.service    = svc_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: random key/joystick/rotate traffic against a key-state model,
// then directed latency, coin pulse, pending, simultaneity, reset and start-coin steps.
module tb_arcade_input_ctrl;
  localparam int CLK_HZ = 4000, COIN_MS = 3, COIN_GAP_MS = 2, CPM = CLK_HZ / 1000;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  arcade_input_ctrl_if io ();

  arcade_input_ctrl #(.CLK_HZ(CLK_HZ), .COIN_MS(COIN_MS), .COIN_GAP_MS(COIN_GAP_MS)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .io      (io.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit tog = 1'b0;
  bit held [512];
  int p1_rise[$], p1_fall[$], p2_rise[$];
  logic p1c_prev = 1'b0, p2c_prev = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (io.p1_csjudlr[6] && !p1c_prev) p1_rise.push_back(cyc);
    if (!io.p1_csjudlr[6] && p1c_prev) p1_fall.push_back(cyc);
    if (io.p2_csjudlr[6] && !p2c_prev) p2_rise.push_back(cyc);
    p1c_prev = io.p1_csjudlr[6];
    p2c_prev = io.p2_csjudlr[6];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic send_key(input bit pressed, input logic [8:0] code);
    tog = ~tog;
    io.ps2_key = {tog, pressed, code};
  endtask

  task automatic clear_q();
    p1_rise.delete();
    p1_fall.delete();
    p2_rise.delete();
  endtask

  // P1 arrow keys answer to either extended-prefix value
  function automatic logic [8:0] norm(input logic [8:0] c);
    if (c[7:0] inside {8'h75, 8'h72, 8'h6B, 8'h74}) return {1'b0, c[7:0]};
    return c;
  endfunction

  function automatic logic [5:0] exp_p1(input logic [7:0] j, input bit rot);
    bit u, d, l, r, f, s;
    u = held[9'h075] | j[3];
    d = held[9'h072] | j[2];
    l = held[9'h06B] | j[1];
    r = held[9'h074] | j[0];
    f = held[9'h029] | held[9'h014] | j[4];
    s = held[9'h005] | held[9'h016] | j[5];
    return rot ? {s, f, l, r, d, u} : {s, f, u, d, l, r};
  endfunction

  function automatic logic [5:0] exp_p2(input logic [7:0] j, input bit rot);
    bit u, d, l, r, f, s;
    u = held[9'h02D] | j[3];
    d = held[9'h02B] | j[2];
    l = held[9'h023] | j[1];
    r = held[9'h034] | j[0];
    f = held[9'h01C];
    s = held[9'h006] | held[9'h01E] | j[6];
    return rot ? {s, f, l, r, d, u} : {s, f, u, d, l, r};
  endfunction

  initial begin
    logic [7:0] codes [18];
    logic [7:0] jj;
    logic [8:0] code;
    bit pr;
    int t0, r0, f0, r1, f1;

    codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h16, 8'h2D,
              8'h2B, 8'h23, 8'h34, 8'h1C, 8'h06, 8'h1E, 8'h2C, 8'h4A, 8'h5A};
    io.ps2_key    = '0;
    io.joystick_0 = '0;
    io.joystick_1 = '0;
    io.rotate     = 1'b0;
    foreach (held[i]) held[i] = 1'b0;

    step(3);
    chk("reset_p1", io.p1_csjudlr, 7'd0);
    chk("reset_p2", io.p2_csjudlr, 7'd0);
    chk("reset_svc", io.service, 1'b0);
    reset_n = 1'b1;
    step(2);

    // random traffic: key events, joystick and orientation changes, often in the same cycle
    for (int it = 0; it < 200; it++) begin
      io.joystick_0 = 16'($urandom) & 16'hFF7F;
      io.joystick_1 = 16'($urandom) & 16'hFF7F;
      io.rotate     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) begin
        code = {($urandom_range(0, 3) == 0), codes[$urandom_range(0, 17)]};
        pr   = 1'($urandom_range(0, 1));
        send_key(pr, code);
        held[norm(code)] = pr;
      end
      step(2);
      jj = io.joystick_0[7:0] | io.joystick_1[7:0];
      chk("rnd_p1", io.p1_csjudlr[5:0], exp_p1(jj, io.rotate));
      chk("rnd_p2", io.p2_csjudlr[5:0], exp_p2(jj, io.rotate));
      chk("rnd_svc", io.service, held[9'h02C]);
    end

    reset_n       = 1'b0;
    io.ps2_key    = '0;
    tog           = 1'b0;
    io.joystick_0 = '0;
    io.joystick_1 = '0;
    io.rotate     = 1'b0;
    foreach (held[i]) held[i] = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);

    send_key(1'b1, 9'h075);
    step();
    chk("key_up_lat1", io.p1_csjudlr[3], 1'b0);
    step();
    chk("key_up_lat2", io.p1_csjudlr[3], 1'b1);
    send_key(1'b0, 9'h075);
    step(2);
    chk("key_up_rel", io.p1_csjudlr[3], 1'b0);
    send_key(1'b1, 9'h175);
    step(2);
    chk("key_eup_lat2", io.p1_csjudlr[3], 1'b1);
    send_key(1'b0, 9'h175);
    step(2);
    chk("key_eup_rel", io.p1_csjudlr[3], 1'b0);

    io.joystick_0 = 16'h0008;
    io.rotate     = 1'b1;
    step();
    chk("rot_p1_dirs", io.p1_csjudlr[3:0], 4'b0001);
    io.rotate = 1'b0;
    step();
    chk("vert_p1_dirs", io.p1_csjudlr[3:0], 4'b1000);
    chk("vert_p2_dirs", io.p2_csjudlr[3:0], 4'b1000);
    io.joystick_0 = '0;
    step(2);

    clear_q();
    t0 = cyc;
    send_key(1'b1, 9'h02E);
    step();
    send_key(1'b0, 9'h02E);
    step(40);
    chk("coin1_rises", p1_rise.size(), 1);
    chk("coin1_falls", p1_fall.size(), 1);
    r0 = (p1_rise.size() > 0) ? p1_rise[0] : -1000;
    f0 = (p1_fall.size() > 0) ? p1_fall[0] : -1000;
    chk("coin1_latency", r0 - t0, 2);
    chk_rng("coin1_width", f0 - r0, (COIN_MS - 1) * CPM + 1, COIN_MS * CPM);

    // second press lands in the pulse (pending), third one is dropped
    clear_q();
    for (int k = 0; k < 3; k++) begin
      send_key(1'b1, 9'h02E);
      step(2);
      send_key(1'b0, 9'h02E);
      step(2);
    end
    step(60);
    chk("pend_rises", p1_rise.size(), 2);
    chk("pend_falls", p1_fall.size(), 2);
    r0 = (p1_rise.size() > 0) ? p1_rise[0] : -1000;
    f0 = (p1_fall.size() > 0) ? p1_fall[0] : -1000;
    r1 = (p1_rise.size() > 1) ? p1_rise[1] : -1000;
    f1 = (p1_fall.size() > 1) ? p1_fall[1] : -1000;
    chk_rng("pend_width0", f0 - r0, (COIN_MS - 1) * CPM + 1, COIN_MS * CPM);
    chk_rng("pend_gap", r1 - f0, COIN_GAP_MS * CPM, COIN_GAP_MS * CPM + CPM);
    chk_rng("pend_width1", f1 - r1, (COIN_MS - 1) * CPM + 1, COIN_MS * CPM);

    clear_q();
    send_key(1'b1, 9'h036);
    step();
    io.joystick_0 = 16'h0080;
    step(30);
    chk("sim_p1_rises", p1_rise.size(), 1);
    chk("sim_p2_rises", p2_rise.size(), 1);
    r0 = (p1_rise.size() > 0) ? p1_rise[0] : -1000;
    r1 = (p2_rise.size() > 0) ? p2_rise[0] : -2000;
    chk("sim_same_clk", r0, r1);
    send_key(1'b0, 9'h036);
    io.joystick_0 = '0;
    step(30);

    send_key(1'b1, 9'h02E);
    step(4);
    chk("pre_reset_coin", io.p1_csjudlr[6], 1'b1);
    reset_n    = 1'b0;
    io.ps2_key = '0;
    tog        = 1'b0;
    #1;
    chk("reset_async_p1", io.p1_csjudlr, 7'd0);
    chk("reset_async_p2", io.p2_csjudlr, 7'd0);
    step(2);
    reset_n = 1'b1;
    clear_q();
    step(40);
    chk("post_reset_no_pulse", p1_rise.size(), 0);

    clear_q();
    t0 = cyc;
    io.joystick_0 = 16'h0020;
    step();
    chk("start1_joy", io.p1_csjudlr[5], 1'b1);
    step(30);
`ifdef COIN_FROM_START_EN
    chk("start_coin_rises", p1_rise.size(), 1);
    r0 = (p1_rise.size() > 0) ? p1_rise[0] : -1000;
    chk("start_coin_latency", r0 - t0, 1);
`else
    chk("start_no_coin", p1_rise.size(), 0);
`endif
    io.joystick_0 = '0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
